// File: rtl/pwm_led_dimmer.sv
// pwm_led_dimmer: N-channel LED output stage. A shared free-running PWM gates
// every logic input. Two debounced push-buttons step the duty up or down.
// A new duty is only adopted at the PWM wrap, so a period never mixes two duties.
module pwm_led_dimmer #(
  parameter int NUM_LEDS      = 5,
  parameter int PWM_BITS      = 8,
  parameter int DEBOUNCE_BITS = 16,
  parameter int DUTY_STEP     = 8,
  parameter int DUTY_INIT     = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                BTN_UP,
  input  logic                BTN_DOWN,
  input  logic [NUM_LEDS-1:0] LED_IN,
  output logic [NUM_LEDS-1:0] LED_OUT,
  output logic [PWM_BITS-1:0] DUTY
);

  localparam logic [PWM_BITS-1:0]      PWM_MAX  = '1;
  localparam logic [DEBOUNCE_BITS-1:0] DB_MAX   = '1;
  localparam logic [PWM_BITS-1:0]      INIT_VAL = PWM_BITS'(DUTY_INIT);
  localparam logic [PWM_BITS:0]        STEP_W   = (PWM_BITS+1)'(DUTY_STEP);
  localparam logic [PWM_BITS:0]        MAX_W    = {1'b0, PWM_MAX};

  // PWM and LED output state
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [NUM_LEDS-1:0] led_q, led_d;

  // Button path state; index 0 is the up button, index 1 the down button
  logic [1:0]                          btn_raw;
  logic [1:0]                          sync1_q, sync2_q;
  logic [1:0]                          db_state_q, db_state_d;
  logic [1:0][DEBOUNCE_BITS-1:0]       db_cnt_q, db_cnt_d;
  logic [1:0]                          press;

  // Duty registers: pending collects presses, active drives the comparator
  logic [PWM_BITS-1:0] duty_pending_q, duty_pending_d;
  logic [PWM_BITS-1:0] duty_active_q, duty_active_d;
  logic [PWM_BITS:0]   duty_sum, duty_diff;

  assign btn_raw = {BTN_DOWN, BTN_UP};

  // Counter advance and PWM gating of every channel
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    led_d     = LED_IN & {NUM_LEDS{pwm_cnt_q < duty_active_q}};
  end

  // Debounce: the synchronised level must differ from the accepted state for
  // the full counter range before it is taken; a rising acceptance is a press
  always_comb begin
    db_state_d = db_state_q;
    db_cnt_d   = '0;
    press      = '0;
    for (int b = 0; b < 2; b++) begin
      if (sync2_q[b] != db_state_q[b]) begin
        if (db_cnt_q[b] == DB_MAX) begin
          db_state_d[b] = sync2_q[b];
          press[b]      = sync2_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + DEBOUNCE_BITS'(1);
        end
      end
    end
  end

  // Saturating duty step computed one bit wider so it can never wrap;
  // simultaneous presses cancel, and the pending value is applied only at wrap
  always_comb begin
    duty_sum       = {1'b0, duty_pending_q} + STEP_W;
    duty_diff      = {1'b0, duty_pending_q} - STEP_W;
    duty_pending_d = duty_pending_q;
    if (press == 2'b01) begin
      duty_pending_d = (duty_sum > MAX_W) ? PWM_MAX : duty_sum[PWM_BITS-1:0];
    end else if (press == 2'b10) begin
      duty_pending_d = duty_diff[PWM_BITS] ? '0 : duty_diff[PWM_BITS-1:0];
    end
    duty_active_d = (pwm_cnt_q == PWM_MAX) ? duty_pending_q : duty_active_q;
  end

  // PWM counter and registered LED drive
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pwm_cnt_q <= '0;
      led_q     <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      led_q     <= led_d;
    end
  end

  // Two-flop synchronisers and debounce registers for both buttons
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      db_state_q <= '0;
      db_cnt_q   <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      db_state_q <= db_state_d;
      db_cnt_q   <= db_cnt_d;
    end
  end

  // Pending and active duty registers; reset drops any unapplied step
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      duty_pending_q <= INIT_VAL;
      duty_active_q  <= INIT_VAL;
    end else begin
      duty_pending_q <= duty_pending_d;
      duty_active_q  <= duty_active_d;
    end
  end

  assign LED_OUT = led_q;
  assign DUTY    = duty_active_q;

endmodule

// File: tb/tb_pwm_led_dimmer.sv
// tb_pwm_led_dimmer: directed scenarios for the PWM LED dimmer with a small
// 4-bit PWM and a short debounce so every behaviour fits in a few periods.
module tb_pwm_led_dimmer;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       BTN_UP = 1'b0;
  logic       BTN_DOWN = 1'b0;
  logic [4:0] LED_IN = 5'b11111;
  logic [4:0] LED_OUT;
  logic [3:0] DUTY;

  int checks = 0;
  int errors = 0;

  // Expected PWM phase: the counter value the DUT holds after each edge
  logic [3:0] phase = 4'd0;

  pwm_led_dimmer #(
    .NUM_LEDS(5),
    .PWM_BITS(4),
    .DEBOUNCE_BITS(2),
    .DUTY_STEP(4),
    .DUTY_INIT(4)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .BTN_UP(BTN_UP),
    .BTN_DOWN(BTN_DOWN),
    .LED_IN(LED_IN),
    .LED_OUT(LED_OUT),
    .DUTY(DUTY)
  );

  // 10 ns clock
  always #5 CLK = ~CLK;

  // Free-running phase tracker, cleared by reset like the PWM counter
  always @(posedge CLK) begin
    if (!RST_N) phase <= 4'd0;
    else        phase <= phase + 4'd1;
  end

  // Safety net so the run can never hang
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to a negedge where the counter holds p (bounded wait)
  task automatic wait_phase(input logic [3:0] p);
    int n;
    n = 0;
    while (phase != p && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (phase != p) begin
      errors++;
      $display("[TB] FAIL wait_phase: phase %0d, required %0d", phase, p);
    end
  endtask

  // LED_OUT at a negedge reflects the counter value one cycle earlier
  task automatic check_led(input logic [3:0] duty, input logic [4:0] pat,
                           input int n, input string name);
    logic [3:0] prev;
    logic [4:0] exp;
    LED_IN = pat;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      prev = phase - 4'd1;
      exp  = (prev < duty) ? pat : 5'd0;
      checks++;
      if (LED_OUT !== exp) begin
        errors++;
        $display("[TB] FAIL %s: cnt=%0d LED_OUT=%b, required %b", name, prev, LED_OUT, exp);
      end
    end
  endtask

  // One 16-cycle press/release starting at phase 1; the step lands in pending
  // at phase 7 and DUTY may only change at the wrap (phase 0)
  task automatic press_check(input logic up, input logic dn, input logic [3:0] old_d,
                             input logic [3:0] new_d, input string name);
    logic [3:0] exp;
    wait_phase(4'd1);
    BTN_UP   = up;
    BTN_DOWN = dn;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      if (i == 7) begin
        BTN_UP   = 1'b0;
        BTN_DOWN = 1'b0;
      end
      exp = (phase == 4'd0 || phase == 4'd1) ? new_d : old_d;
      checks++;
      if (DUTY !== exp) begin
        errors++;
        $display("[TB] FAIL %s: phase=%0d DUTY=%0d, required %0d", name, phase, DUTY, exp);
      end
    end
  endtask

  task automatic expect_duty(input logic [3:0] d, input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      checks++;
      if (DUTY !== d) begin
        errors++;
        $display("[TB] FAIL %s: phase=%0d DUTY=%0d, required %0d", name, phase, DUTY, d);
      end
    end
  endtask

  task automatic test_reset();
    RST_N    = 1'b0;
    BTN_UP   = 1'b0;
    BTN_DOWN = 1'b0;
    LED_IN   = 5'b11111;
    repeat (3) @(negedge CLK);
    checks += 2;
    if (LED_OUT !== 5'd0) begin
      errors++;
      $display("[TB] FAIL reset_led: LED_OUT=%b, required 00000", LED_OUT);
    end
    if (DUTY !== 4'd4) begin
      errors++;
      $display("[TB] FAIL reset_duty: DUTY=%0d, required 4", DUTY);
    end
    RST_N = 1'b1;
    check_led(4'd4, 5'b11111, 32, "led_duty4");
  endtask

  task automatic test_glitch();
    wait_phase(4'd1);
    BTN_UP = 1'b1;
    repeat (2) @(negedge CLK);
    BTN_UP = 1'b0;
    expect_duty(4'd4, 30, "glitch_no_step");
  endtask

  task automatic test_reset_mid_press();
    wait_phase(4'd1);
    BTN_UP = 1'b1;
    expect_duty(4'd4, 8, "pre_reset_duty");
    BTN_UP = 1'b0;
    RST_N  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks += 2;
      if (LED_OUT !== 5'd0) begin
        errors++;
        $display("[TB] FAIL midreset_led: LED_OUT=%b, required 00000", LED_OUT);
      end
      if (DUTY !== 4'd4) begin
        errors++;
        $display("[TB] FAIL midreset_duty: DUTY=%0d, required 4", DUTY);
      end
    end
    RST_N = 1'b1;
    expect_duty(4'd4, 40, "post_reset_duty");
    check_led(4'd4, 5'b01011, 16, "led_after_reset");
  endtask

  task automatic test_up_hold();
    logic       wrapped;
    logic [3:0] exp;
    wrapped = 1'b0;
    wait_phase(4'd1);
    BTN_UP = 1'b1;
    for (int i = 0; i < 48; i++) begin
      @(negedge CLK);
      if (phase == 4'd0) wrapped = 1'b1;
      exp = wrapped ? 4'd8 : 4'd4;
      checks++;
      if (DUTY !== exp) begin
        errors++;
        $display("[TB] FAIL up_hold: phase=%0d DUTY=%0d, required %0d", phase, DUTY, exp);
      end
    end
    BTN_UP = 1'b0;
    expect_duty(4'd8, 20, "up_release");
    check_led(4'd8, 5'b01101, 16, "led_duty8");
  endtask

  task automatic test_both();
    press_check(1'b1, 1'b1, 4'd8, 4'd8, "both_buttons");
  endtask

  task automatic test_down_floor();
    press_check(1'b0, 1'b1, 4'd8, 4'd4, "down_8_to_4");
    press_check(1'b0, 1'b1, 4'd4, 4'd0, "down_4_to_0");
    press_check(1'b0, 1'b1, 4'd0, 4'd0, "down_floor");
    check_led(4'd0, 5'b11111, 32, "led_duty0");
  endtask

  task automatic test_up_saturate();
    press_check(1'b1, 1'b0, 4'd0, 4'd4, "up_0_to_4");
    press_check(1'b1, 1'b0, 4'd4, 4'd8, "up_4_to_8");
    press_check(1'b1, 1'b0, 4'd8, 4'd12, "up_8_to_12");
    press_check(1'b1, 1'b0, 4'd12, 4'd15, "up_12_to_15");
    for (int k = 0; k < 4; k++) press_check(1'b1, 1'b0, 4'd15, 4'd15, "up_ceiling");
    check_led(4'd15, 5'b10110, 32, "led_duty15");
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_reset_mid_press();
    test_up_hold();
    test_both();
    test_down_floor();
    test_up_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
